// File: rtl/elm_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package elm_arb_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int unsigned MUL_LAT_MAX = 8;
  localparam int unsigned CNT_W       = 4;

  // One in-flight product: valid flag and owning requester.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Handshake, multiplier and response signals between the arbiter and its neighbours.
interface mult_share_arbiter_if #(
  parameter int unsigned N = 16
) ();
  import elm_arb_pkg::*;

  logic             en;
  logic             req0_valid;
  logic             req0_ready;
  logic             req1_valid;
  logic             req1_ready;
  logic             mux_sel;
  logic             mul_in_valid;
  logic             mul_out_valid;
  logic [2*N-1:0]   mul_out;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [2*N-1:0]   rsp_data;
  logic [CNT_W-1:0] outstanding;
  logic             err;

  modport slave (
    input  en, req0_valid, req1_valid, mul_out_valid, mul_out,
    output req0_ready, req1_ready, mux_sel, mul_in_valid,
           rsp0_valid, rsp1_valid, rsp_data, outstanding, err
  );

  modport master (
    output en, req0_valid, req1_valid, mul_out_valid, mul_out,
    input  req0_ready, req1_ready, mux_sel, mul_in_valid,
           rsp0_valid, rsp1_valid, rsp_data, outstanding, err
  );

endinterface

// File: rtl/arb_tag_pipe.sv
// DEPTH-stage shift register of ownership tags, mirroring the multiplier pipeline.
module arb_tag_pipe
  import elm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters,
// steering each product back to the requester that issued it.
module mult_share_arbiter
  import elm_arb_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned MUL_LAT = 3
) (
  input logic                 clk,
  input logic                 rst,
  mult_share_arbiter_if.slave bus
);

  // Latency clamped into the supported 1..MUL_LAT_MAX window.
  localparam int unsigned LAT = (MUL_LAT < 1) ? 1 :
                                (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;

  logic             last_grant_q, last_grant_d;
  logic             mux_sel_q, mux_sel_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] guard_q, guard_d;

  logic             grant0_c, grant1_c, hs_c, gnt_id_c;
  logic             live_c, rsp_fire_c;
  logic [2*N-1:0]   rsp_data_c;
  tag_t             tag_in, tag_tail;

  // Grant decision: alternate under contention, no grants while disabled or in reset.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (bus.en && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_c = (last_grant_q == REQ1);
        grant1_c = (last_grant_q == REQ0);
      end else begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid;
      end
    end
    hs_c       = grant0_c | grant1_c;
    gnt_id_c   = grant1_c ? REQ1 : REQ0;
    tag_in.vld = hs_c;
    tag_in.id  = gnt_id_c;
  end

  // Results are honoured only outside reset and once the post-reset guard has expired.
  always_comb begin
    live_c     = !rst && (guard_q == '0);
    rsp_fire_c = live_c && bus.mul_out_valid && tag_tail.vld;
    rsp_data_c = bus.mul_out;
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    mux_sel_d     = mux_sel_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    guard_d       = guard_q;

    if (hs_c) begin
      last_grant_d = gnt_id_c;
      mux_sel_d    = gnt_id_c;
    end

    unique case ({hs_c, tag_tail.vld})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // A result without a tag, or a tag without a result, means the pipes disagree.
    if (live_c && (bus.mul_out_valid != tag_tail.vld)) begin
      err_d = 1'b1;
    end

    if (guard_q != '0) begin
      guard_d = guard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= REQ1;
      mux_sel_q     <= REQ0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      guard_q       <= CNT_W'(LAT);
    end else begin
      last_grant_q  <= last_grant_d;
      mux_sel_q     <= mux_sel_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      guard_q       <= guard_d;
    end
  end

  arb_tag_pipe #(
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .flush   (rst),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  assign bus.req0_ready   = grant0_c;
  assign bus.req1_ready   = grant1_c;
  assign bus.mul_in_valid = hs_c;
  assign bus.mux_sel      = hs_c ? gnt_id_c : mux_sel_q;
  assign bus.rsp0_valid   = rsp_fire_c && (tag_tail.id == REQ0);
  assign bus.rsp1_valid   = rsp_fire_c && (tag_tail.id == REQ1);
  assign bus.rsp_data     = rsp_data_c;
  assign bus.outstanding  = outstanding_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural 3-cycle multiplier and operand muxes.
module tb_mult_share_arbiter;
  import elm_arb_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned L  = 3;
  localparam int unsigned PW = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.N(N)) bus ();

  mult_share_arbiter #(
    .N       (N),
    .MUL_LAT (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Operand sources, operand muxes and the shared multiplier model.
  logic [N-1:0]  a0, b0, a1, b1;
  logic          inject;
  logic [L-1:0]  mp_v = '0;
  logic [PW-1:0] mp_d [L];
  logic [N-1:0]  a_mux, b_mux;

  assign a_mux = bus.mux_sel ? a1 : a0;
  assign b_mux = bus.mux_sel ? b1 : b0;

  always @(posedge clk) begin
    mp_v    <= {mp_v[L-2:0], bus.mul_in_valid};
    mp_d[0] <= PW'(a_mux) * PW'(b_mux);
    for (int i = 1; i < L; i++) mp_d[i] <= mp_d[i-1];
  end

  assign bus.mul_out_valid = mp_v[L-1] | inject;
  assign bus.mul_out       = inject ? 32'hDEAD_BEEF : mp_d[L-1];

  typedef struct {
    logic          id;
    int unsigned   due;
    logic [PW-1:0] data;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc;
  logic        exp_last, exp_mux, exp_err;
  int unsigned exp_guard;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned max_out = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check combinational/registered outputs against the model, then advance.
  task automatic tick();
    logic        ok, g, gid, due, err_next;
    logic [PW-1:0] prod;
    #2;
    ok  = bus.en && !rst;
    g   = 1'b0;
    gid = REQ0;
    if (ok) begin
      if (bus.req0_valid && bus.req1_valid) begin g = 1'b1; gid = ~exp_last; end
      else if (bus.req0_valid)              begin g = 1'b1; gid = REQ0;      end
      else if (bus.req1_valid)              begin g = 1'b1; gid = REQ1;      end
    end
    check("req0_ready",   64'(bus.req0_ready),   64'(g && gid == REQ0));
    check("req1_ready",   64'(bus.req1_ready),   64'(g && gid == REQ1));
    check("mul_in_valid", 64'(bus.mul_in_valid), 64'(g));
    check("mux_sel",      64'(bus.mux_sel),      64'(g ? gid : exp_mux));
    check("outstanding",  64'(bus.outstanding),  64'(sbq.size()));
    if (int'(bus.outstanding) > int'(max_out)) max_out = bus.outstanding;

    due = !rst && exp_guard == 0 && sbq.size() != 0 && sbq[0].due == cyc;
    if (due) begin
      check("rsp0_valid", 64'(bus.rsp0_valid), 64'(sbq[0].id == REQ0));
      check("rsp1_valid", 64'(bus.rsp1_valid), 64'(sbq[0].id == REQ1));
      check("rsp_data",   64'(bus.rsp_data),   64'(sbq[0].data));
      void'(sbq.pop_front());
    end else begin
      check("rsp_idle", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'(0));
    end
    check("err", 64'(bus.err), 64'(exp_err));
    err_next = exp_err | (!rst && exp_guard == 0 && inject && !due);

    if (g) begin
      prod = (gid == REQ1) ? PW'(a1) * PW'(b1) : PW'(a0) * PW'(b0);
      sbq.push_back('{id: gid, due: cyc + L, data: prod});
    end

    @(posedge clk);
    #1;
    cyc++;
    if (g) begin
      exp_last = gid;
      exp_mux  = gid;
    end
    if (rst) begin
      sbq.delete();
      exp_guard = L;
      exp_last  = REQ1;
      exp_mux   = REQ0;
      exp_err   = 1'b0;
    end else begin
      if (exp_guard > 0) exp_guard--;
      exp_err = err_next;
    end
  endtask

  task automatic idle(input int n);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_ops();
    a0 = N'($urandom); b0 = N'($urandom);
    a1 = N'($urandom); b1 = N'($urandom);
  endtask

  initial begin
    bus.en = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    inject = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(posedge clk);
    #1;
    cyc = 0; exp_last = REQ1; exp_mux = REQ0; exp_err = 1'b0; exp_guard = L;

    // Reset holds off grants even with both requesters valid.
    bus.en = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    tick();
    rst = 1'b0;

    // Requester 0 alone: 7*9 five times.
    bus.req1_valid = 1'b0; a0 = 16'd7; b0 = 16'd9;
    repeat (5) tick();
    idle(5);

    // Continuous contention after reset: 0,1,0,1,...
    reset_pulse();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (6) begin rand_ops(); tick(); end
    idle(4);

    // Three in flight, then en low: drains 3,2,1,0.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (3) begin rand_ops(); tick(); end
    bus.en = 1'b0;
    repeat (4) tick();
    bus.en = 1'b1;
    idle(2);

    // Reset with two ops in flight: stale results fall into the guard window.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (2) begin rand_ops(); tick(); end
    reset_pulse();
    idle(6);

    // Orphan result with an empty tag pipe: sticky error, no response.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    idle(3);

    // Requester 1 alone, then contention: first contended grant goes to 0.
    reset_pulse();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b1;
    repeat (2) begin rand_ops(); tick(); end
    bus.req0_valid = 1'b1;
    repeat (5) begin rand_ops(); tick(); end
    idle(5);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      bus.en         = ($urandom_range(0, 3) != 0);
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      rand_ops();
      tick();
    end
    bus.en = 1'b1;
    idle(6);

    check("max_outstanding_ok", 64'(max_out <= L), 64'(1));
    check("scoreboard_empty",   64'(sbq.size()),   64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
